// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus bundle: instruction-memory request/response, decode handoff, redirect.
interface fetch_sequencer_if;
  localparam int unsigned XLEN = 32;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            instr_valid;
  logic            instr_ready;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  // Sequencer side
  modport master (
    output imem_req_valid, imem_addr, instr_valid, instr, instr_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
           redirect_valid, redirect_pc
  );

  // Memory / decode / execute side
  modport slave (
    input  imem_req_valid, imem_addr, instr_valid, instr, instr_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
           redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_sequencer.sv
// In-order instruction fetch sequencer with PC queue, instruction FIFO and redirect flush.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  fetch_sequencer_if.master bus
);
  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 3;
  localparam int unsigned PTR_W = 2;
  localparam int unsigned SLOTS = 4;

  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_e;

  state_e           state_q, state_d;
  logic [XLEN-1:0]  fetch_pc_q;
  logic [XLEN-1:0]  pcq_mem [SLOTS];
  logic [PTR_W-1:0] pcq_wr_q, pcq_rd_q;
  logic [CNT_W-1:0] outstanding_q;
  logic [CNT_W-1:0] stale_q, stale_d;
  logic [XLEN-1:0]  fifo_instr [SLOTS];
  logic [XLEN-1:0]  fifo_pc [SLOTS];
  logic [PTR_W-1:0] fifo_wr_q, fifo_rd_q;
  logic [CNT_W-1:0] fifo_cnt_q;

  logic [CNT_W:0]   inflight_c;
  logic [XLEN-1:0]  redirect_pc_c;
  logic             redirect_c, req_valid_c, req_fire_c, rsp_fire_c, rsp_keep_c, fifo_pop_c;

  // Circular pointer advance that wraps at DEPTH rather than at the storage size
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + PTR_W'(1);
  endfunction

  assign redirect_c    = bus.redirect_valid;
  assign redirect_pc_c = bus.redirect_pc & ~XLEN'(3);
  assign inflight_c    = (CNT_W+1)'(outstanding_q) + (CNT_W+1)'(fifo_cnt_q);
  assign req_fire_c    = req_valid_c && bus.imem_req_ready;
  assign rsp_fire_c    = bus.imem_rsp_valid;
  assign rsp_keep_c    = rsp_fire_c && (stale_q == '0) && !redirect_c;
  assign fifo_pop_c    = (fifo_cnt_q != '0) && bus.instr_ready && !redirect_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= BOOT;
    else        state_q <= state_d;
  end

  // Next state plus next stale count; a redirect marks everything still in flight as stale
  always_comb begin
    state_d = state_q;
    stale_d = stale_q;
    if (redirect_c)                       stale_d = outstanding_q - CNT_W'(rsp_fire_c);
    else if (rsp_fire_c && stale_q != '0) stale_d = stale_q - CNT_W'(1);
    unique case (state_q)
      BOOT:       state_d = RUN;
      RUN, FLUSH: state_d = (stale_d != '0) ? FLUSH : RUN;
      default:    state_d = BOOT;
    endcase
  end

  // Outputs: request gating on registered occupancy, FIFO head to decode
  always_comb begin
    req_valid_c = 1'b0;
    if (state_q != BOOT && inflight_c < (CNT_W+1)'(DEPTH) && !redirect_c) req_valid_c = 1'b1;
    bus.imem_req_valid = req_valid_c;
    bus.imem_addr      = fetch_pc_q;
    bus.instr_valid    = (fifo_cnt_q != '0);
    bus.instr          = fifo_instr[fifo_rd_q];
    bus.instr_pc       = fifo_pc[fifo_rd_q];
  end

  // Fetch PC, PC-queue pointers and occupancy counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      pcq_wr_q      <= '0;
      pcq_rd_q      <= '0;
      outstanding_q <= '0;
      stale_q       <= '0;
      fifo_wr_q     <= '0;
      fifo_rd_q     <= '0;
      fifo_cnt_q    <= '0;
    end else begin
      stale_q       <= stale_d;
      outstanding_q <= outstanding_q + CNT_W'(req_fire_c) - CNT_W'(rsp_fire_c);
      if (redirect_c)      fetch_pc_q <= redirect_pc_c;
      else if (req_fire_c) fetch_pc_q <= fetch_pc_q + XLEN'(4);
      if (req_fire_c) pcq_wr_q <= ptr_inc(pcq_wr_q);
      if (rsp_fire_c) pcq_rd_q <= ptr_inc(pcq_rd_q);
      if (redirect_c) begin
        fifo_wr_q  <= '0;
        fifo_rd_q  <= '0;
        fifo_cnt_q <= '0;
      end else begin
        if (rsp_keep_c) fifo_wr_q <= ptr_inc(fifo_wr_q);
        if (fifo_pop_c) fifo_rd_q <= ptr_inc(fifo_rd_q);
        fifo_cnt_q <= fifo_cnt_q + CNT_W'(rsp_keep_c) - CNT_W'(fifo_pop_c);
      end
    end
  end

  // PC queue and instruction FIFO storage; cleared on reset so instr/instr_pc read zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcq_mem    <= '{default: '0};
      fifo_instr <= '{default: '0};
      fifo_pc    <= '{default: '0};
    end else begin
      if (req_fire_c) pcq_mem[pcq_wr_q] <= fetch_pc_q;
      if (rsp_keep_c) begin
        fifo_instr[fifo_wr_q] <= bus.imem_rsp_data;
        fifo_pc[fifo_wr_q]    <= pcq_mem[pcq_rd_q];
      end
    end
  end

  // Occupancy gating guarantees a kept response always finds room
  a_fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    rsp_keep_c |-> (fifo_cnt_q < CNT_W'(DEPTH)));

  a_inflight_bound: assert property (@(posedge clk) disable iff (!rst_n)
    inflight_c <= (CNT_W+1)'(DEPTH));
endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench: memory model + scoreboard of expected decode stream, redirect vector table.
module tb_fetch_sequencer;
  localparam int unsigned DEPTH  = 2;
  localparam logic [31:0] MAGIC  = 32'hC0DE_5A5A;
  localparam logic [31:0] ALT_PC = 32'hFFFF_FFF8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_sequencer_if ifc ();
  fetch_sequencer_if ifc2 ();

  fetch_sequencer #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .bus(ifc));
  fetch_sequencer #(.RESET_PC(ALT_PC), .DEPTH(DEPTH)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(ifc2));

  typedef struct { logic [31:0] addr; int t; bit killed; } mreq_t;
  typedef struct { int mode; int lat; logic [31:0] target; logic [31:0] exp_addr; int warm; } rvec_t;

  mreq_t       mem_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] q2[$];
  rvec_t       vecs[5];

  int          cyc, lat, n_chk, n_pass, n_acc, n_acc2, n_deliv, redir_stale, arm_mode;
  bit          dec_rdy, rand_rdy, fired, want_first, prev_stall;
  logic [31:0] arm_pc, next_addr, next_addr2, last_acc, first_pc, prev_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic expire(input string name);
    n_chk++;
    $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
  endtask

  // One clock: drive at negedge, settle, model/check, advance to next negedge
  task automatic cycle();
    bit          trig;
    logic [1:0]  st;
    logic [31:0] e;
    if (mem_q.size() != 0 && cyc >= mem_q[0].t + lat) begin
      ifc.imem_rsp_valid = 1'b1;
      ifc.imem_rsp_data  = mem_q[0].addr ^ MAGIC;
    end else begin
      ifc.imem_rsp_valid = 1'b0;
      ifc.imem_rsp_data  = '0;
    end
    ifc.imem_req_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    ifc.instr_ready    = dec_rdy;
    ifc.redirect_valid = 1'b0;
    ifc.redirect_pc    = '0;
    ifc2.imem_rsp_valid = (q2.size() != 0);
    ifc2.imem_rsp_data  = (q2.size() != 0) ? (q2[0] ^ MAGIC) : '0;
    ifc2.imem_req_ready = 1'b1;
    ifc2.instr_ready    = 1'b1;
    ifc2.redirect_valid = 1'b0;
    ifc2.redirect_pc    = '0;
    #1;
    if (arm_mode != 0 && !fired) begin
      case (arm_mode)
        1:       trig = ifc.imem_rsp_valid && ifc.instr_valid && ifc.instr_ready;
        2:       trig = (mem_q.size() == 2) && !ifc.imem_rsp_valid;
        default: trig = 1'b1;
      endcase
      if (trig) begin
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc    = arm_pc;
        fired              = 1'b1;
      end
    end
    #1;
    chk("instr_valid", 32'(ifc.instr_valid), 32'(exp_q.size() != 0));
    if (prev_stall && !ifc.redirect_valid) begin
      chk("req_valid_hold", 32'(ifc.imem_req_valid), 32'd1);
      chk("req_addr_hold", ifc.imem_addr, prev_addr);
    end
    prev_stall = ifc.imem_req_valid && !ifc.imem_req_ready;
    prev_addr  = ifc.imem_addr;
    if (ifc.instr_valid && ifc.instr_ready && !ifc.redirect_valid && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("instr_pc", ifc.instr_pc, e);
      chk("instr", ifc.instr, e ^ MAGIC);
      n_deliv++;
      if (want_first) begin
        first_pc   = ifc.instr_pc;
        want_first = 1'b0;
      end
    end
    if (ifc.imem_rsp_valid) begin
      if (!mem_q[0].killed && !ifc.redirect_valid) exp_q.push_back(mem_q[0].addr);
      void'(mem_q.pop_front());
    end
    if (ifc.imem_req_valid && ifc.imem_req_ready) begin
      chk("imem_addr", ifc.imem_addr, next_addr);
      mem_q.push_back('{addr: ifc.imem_addr, t: cyc, killed: 1'b0});
      next_addr = next_addr + 32'd4;
      last_acc  = ifc.imem_addr;
      n_acc++;
    end
    if (ifc.redirect_valid) begin
      chk("req_valid_on_redirect", 32'(ifc.imem_req_valid), 32'd0);
      foreach (mem_q[i]) mem_q[i].killed = 1'b1;
      exp_q.delete();
      next_addr   = arm_pc & 32'hFFFF_FFFC;
      redir_stale = mem_q.size();
      want_first  = 1'b1;
    end
    chk("inflight_bound", 32'(mem_q.size() + exp_q.size() <= DEPTH), 32'd1);
    if (ifc2.imem_rsp_valid) void'(q2.pop_front());
    if (ifc2.imem_req_valid && ifc2.imem_req_ready) begin
      chk("alt_addr", ifc2.imem_addr, next_addr2);
      q2.push_back(ifc2.imem_addr);
      next_addr2 = next_addr2 + 32'd4;
      n_acc2++;
    end
    st = dut.state_q;
    @(negedge clk);
    cyc++;
    if (st == 2'd3) chk("state_legal", 32'(st), 32'd0);
  endtask

  // Asynchronous reset pulse with immediate output checks and first-request timing
  task automatic do_reset();
    rst_n = 1'b0;
    ifc.imem_rsp_valid = 1'b0; ifc.imem_rsp_data = '0; ifc.redirect_valid = 1'b0;
    ifc.redirect_pc = '0; ifc.imem_req_ready = 1'b1; ifc.instr_ready = 1'b1;
    ifc2.imem_rsp_valid = 1'b0; ifc2.imem_rsp_data = '0; ifc2.redirect_valid = 1'b0;
    ifc2.redirect_pc = '0; ifc2.imem_req_ready = 1'b1; ifc2.instr_ready = 1'b1;
    #1;
    chk("rst_req_valid", 32'(ifc.imem_req_valid), 32'd0);
    chk("rst_instr_valid", 32'(ifc.instr_valid), 32'd0);
    chk("rst_instr", ifc.instr, 32'd0);
    chk("rst_instr_pc", ifc.instr_pc, 32'd0);
    mem_q.delete(); exp_q.delete(); q2.delete();
    next_addr = 32'h0; next_addr2 = ALT_PC;
    prev_stall = 1'b0; arm_mode = 0; fired = 1'b1; want_first = 1'b0;
    n_acc = 0; n_acc2 = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("boot_no_req", 32'(ifc.imem_req_valid), 32'd0);
    @(negedge clk);
    cyc++;
    #1;
    chk("first_req_valid", 32'(ifc.imem_req_valid), 32'd1);
    chk("first_req_addr", ifc.imem_addr, 32'h0);
    chk("alt_first_addr", ifc2.imem_addr, ALT_PC);
  endtask

  initial begin
    logic [1:0] st;
    int         mark;
    vecs[0] = '{mode: 2, lat: 3, target: 32'h0000_0100, exp_addr: 32'h0000_0100, warm: 0};
    vecs[1] = '{mode: 1, lat: 1, target: 32'h0000_0203, exp_addr: 32'h0000_0200, warm: 1};
    vecs[2] = '{mode: 3, lat: 1, target: 32'hFFFF_FFFE, exp_addr: 32'hFFFF_FFFC, warm: 5};
    vecs[3] = '{mode: 3, lat: 2, target: 32'h0000_1007, exp_addr: 32'h0000_1004, warm: 7};
    vecs[4] = '{mode: 2, lat: 4, target: 32'h0000_0040, exp_addr: 32'h0000_0040, warm: 0};
    cyc = 0; n_chk = 0; n_pass = 0; n_deliv = 0; lat = 1; dec_rdy = 1'b1; rand_rdy = 1'b0;
    arm_pc = '0; redir_stale = 0; first_pc = '0; last_acc = '0; prev_addr = '0;

    // Straight-line stream, then randomly stalled request acceptance
    do_reset();
    repeat (30) cycle();
    chk("stream_delivered", 32'(n_deliv >= 10), 32'd1);
    chk("alt_wrap_seen", 32'(n_acc2 >= 3), 32'd1);
    rand_rdy = 1'b1;
    repeat (40) cycle();
    rand_rdy = 1'b0;

    // Decode backpressure: capacity caps issue, release resumes at 0x8
    do_reset();
    dec_rdy = 1'b0;
    repeat (10) cycle();
    chk("stall_req_count", 32'(n_acc), 32'd2);
    #1 chk("stall_req_valid", 32'(ifc.imem_req_valid), 32'd0);
    dec_rdy = 1'b1;
    for (int i = 0; i < 20 && n_acc < 3; i++) cycle();
    if (n_acc < 3) expire("resume_fetch");
    else chk("resume_addr", last_acc, 32'h8);

    // Redirect vectors
    foreach (vecs[k]) begin
      do_reset();
      lat = vecs[k].lat;
      repeat (vecs[k].warm) cycle();
      arm_mode = vecs[k].mode; arm_pc = vecs[k].target; fired = 1'b0;
      for (int i = 0; i < 30 && !fired; i++) cycle();
      arm_mode = 0;
      if (!fired) expire("redirect_trigger");
      else begin
        #1;
        st = dut.state_q;
        chk("redir_fifo_empty", 32'(ifc.instr_valid), 32'd0);
        chk("redir_addr", ifc.imem_addr, vecs[k].exp_addr);
        chk("redir_state", 32'(st), (redir_stale != 0) ? 32'd2 : 32'd1);
        mark = n_deliv;
        for (int i = 0; i < 40 && n_deliv == mark; i++) cycle();
        if (n_deliv == mark) expire("redir_first_delivery");
        else chk("redir_first_pc", first_pc, vecs[k].exp_addr);
      end
    end

    // Back-to-back redirects: last target wins, stale responses all dropped
    do_reset();
    lat = 3;
    repeat (2) cycle();
    arm_mode = 3; arm_pc = 32'h0000_0300; fired = 1'b0;
    cycle();
    arm_pc = 32'h0000_0404; fired = 1'b0;
    cycle();
    arm_mode = 0;
    #1;
    st = dut.state_q;
    chk("double_redir_addr", ifc.imem_addr, 32'h0000_0404);
    chk("double_redir_state", 32'(st), 32'd2);
    mark = n_deliv;
    for (int i = 0; i < 40 && n_deliv == mark; i++) cycle();
    if (n_deliv == mark) expire("double_redir_delivery");
    else chk("double_redir_first_pc", first_pc, 32'h0000_0404);

    // Mid-stream reset with one request outstanding
    lat = 3;
    repeat (6) cycle();
    for (int i = 0; i < 20 && mem_q.size() != 1; i++) cycle();
    if (mem_q.size() != 1) expire("one_outstanding");
    do_reset();
    lat = 1;
    repeat (15) cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
